scan_display_capture: RTL

- Receive-side counterpart of the 4-digit multiplexed display driver: samples the scanned digit bus (4-bit BCD data plus 4-bit active-low digit select) and rebuilds the four digit values into a parallel register.
- Used on the remote display board and as the in-system monitor for the scan bus.
- Detects scan order, locks to the frame, publishes whole frames atomically and flags protocol errors.

---
 rtl/scan_pkg.sv | 78 +++++++
 rtl/scan_slot_filter.sv | 54 +++++
 rtl/scan_display_capture.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the scan display capture block.
// Holds the FSM state enum, select patterns and the select decoder.
package scan_pkg;

    typedef enum logic [2:0] {
        HUNT,
        EXP0,
        EXP1,
        EXP2,
        EXP3
    } state_t;

    localparam logic [3:0] SL_D0    = 4'b1110;
    localparam logic [3:0] SL_D1    = 4'b1101;
    localparam logic [3:0] SL_D2    = 4'b1011;
    localparam logic [3:0] SL_D3    = 4'b0111;
    localparam logic [3:0] SL_BLANK = 4'b1111;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // legal: exactly one low bit; blank: no low bit; neither: illegal
    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [1:0] idx;
    } slot_t;

    function automatic slot_t sl_decode(input logic [3:0] sl);
        slot_t s;
        s = '0;
        case (sl)
            SL_D0: begin
                s.legal = 1'b1;
                s.idx   = 2'd0;
            end
            SL_D1: begin
                s.legal = 1'b1;
                s.idx   = 2'd1;
            end
            SL_D2: begin
                s.legal = 1'b1;
                s.idx   = 2'd2;
            end
            SL_D3: begin
                s.legal = 1'b1;
                s.idx   = 2'd3;
            end
            SL_BLANK: s.blank = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

    // Slot index expected while in a given EXPn state
    function automatic logic [1:0] state_idx(input state_t st);
        logic [1:0] i;
        case (st)
            EXP1:    i = 2'd1;
            EXP2:    i = 2'd2;
            EXP3:    i = 2'd3;
            default: i = 2'd0;
        endcase
        return i;
    endfunction

    // State that expects a given slot index next
    function automatic state_t exp_state(input logic [1:0] idx);
        state_t st;
        case (idx)
            2'd1:    st = EXP1;
            2'd2:    st = EXP2;
            2'd3:    st = EXP3;
            default: st = EXP0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/scan_slot_filter.sv
// Select stability filter: one acceptance strobe per run of a stable
// one-low pattern. Ports: Clk, Reset, sl in; slot_idx/acc/illegal out.
module scan_slot_filter
    import scan_pkg::*;
#(
    parameter int unsigned STABLE_CYC = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] sl,
    output logic [1:0] slot_idx,
    output logic       slot_acc,
    output logic       slot_illegal
);

    localparam logic [3:0] STB = 4'(STABLE_CYC);

    slot_t      dec;
    logic [3:0] cnt;
    logic [3:0] cnt_n;
    logic [3:0] last;
    logic       same;

    assign dec          = sl_decode(sl);
    assign slot_idx     = dec.idx;
    assign slot_illegal = !dec.legal && !dec.blank;
    assign same         = (cnt != 4'd0) && (sl == last);

    // The count stops at STB so a long run strobes exactly once
    always_comb begin
        cnt_n    = cnt;
        slot_acc = 1'b0;
        if (!dec.legal) begin
            cnt_n = 4'd0;
        end else if (!same) begin
            cnt_n    = 4'd1;
            slot_acc = (STB == 4'd1);
        end else if (cnt < STB) begin
            cnt_n    = cnt + 4'd1;
            slot_acc = (cnt + 4'd1 == STB);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt  <= 4'd0;
            last <= SL_BLANK;
        end else begin
            cnt  <= cnt_n;
            last <= sl;
        end
    end

endmodule

// File: rtl/scan_display_capture.sv
// Rebuilds a 4-digit multiplexed BCD scan into a parallel frame register.
// In: Clk, Reset(async low), Seg_in, Sl_in, Clr_err. Out: Dig, Frame_vld,
// Sync, Err_sel, Err_bcd, Frame_cnt. SCAN_SYNC_EN adds a 2-flop input sync.
module scan_display_capture
    import scan_pkg::*;
#(
    parameter int unsigned STABLE_CYC  = 1,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  Seg_in,
    input  logic [3:0]  Sl_in,
    input  logic        Clr_err,
    output logic [15:0] Dig,
    output logic        Frame_vld,
    output logic        Sync,
    output logic        Err_sel,
    output logic        Err_bcd,
    output logic [7:0]  Frame_cnt
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [7:0] stage_in;
    logic [3:0] r_sl;
    logic [3:0] r_seg;

`ifdef SCAN_SYNC_EN
    logic [7:0] sync1;
    logic [7:0] sync2;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1 <= {SL_BLANK, 4'h0};
            sync2 <= {SL_BLANK, 4'h0};
        end else begin
            sync1 <= {Sl_in, Seg_in};
            sync2 <= sync1;
        end
    end

    assign stage_in = sync2;
`else
    assign stage_in = {Sl_in, Seg_in};
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_sl  <= SL_BLANK;
            r_seg <= 4'h0;
        end else begin
            r_sl  <= stage_in[7:4];
            r_seg <= stage_in[3:0];
        end
    end

    logic [1:0] slot_idx;
    logic       slot_acc;
    logic       slot_illegal;

    scan_slot_filter #(
        .STABLE_CYC(STABLE_CYC)
    ) u_filter (
        .Clk         (Clk),
        .Reset       (Reset),
        .sl          (r_sl),
        .slot_idx    (slot_idx),
        .slot_acc    (slot_acc),
        .slot_illegal(slot_illegal)
    );

    state_t      state;
    logic [3:0]  sh0;
    logic [3:0]  sh1;
    logic [3:0]  sh2;
    logic [15:0] tcnt;
    logic        in_order;
    logic        sel_bad;
    logic        bcd_bad;
    logic        timeout;

    assign in_order = (state != HUNT) && (slot_idx == state_idx(state));
    assign sel_bad  = slot_illegal
                    || (slot_acc && state != HUNT && !in_order);
    assign bcd_bad  = slot_acc && (r_seg > BCD_MAX);
    assign timeout  = !slot_acc && (tcnt == TO_LAST);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= HUNT;
            sh0       <= 4'h0;
            sh1       <= 4'h0;
            sh2       <= 4'h0;
            tcnt      <= 16'd0;
            Dig       <= 16'h0000;
            Frame_vld <= 1'b0;
            Sync      <= 1'b0;
            Err_sel   <= 1'b0;
            Err_bcd   <= 1'b0;
            Frame_cnt <= 8'h00;
        end else begin
            Frame_vld <= 1'b0;
            // a new set in the clearing cycle keeps the flag
            Err_sel   <= sel_bad | (Err_sel & ~Clr_err);
            Err_bcd   <= bcd_bad | (Err_bcd & ~Clr_err);

            if (slot_acc || timeout) begin
                tcnt <= 16'd0;
            end else begin
                tcnt <= tcnt + 16'd1;
            end

            if (slot_illegal) begin
                state <= HUNT;
                Sync  <= 1'b0;
            end else if (slot_acc) begin
                if (!in_order) begin
                    // digit0 always (re)starts a frame, whatever the state
                    if (state != HUNT) begin
                        Sync <= 1'b0;
                    end
                    if (slot_idx == 2'd0) begin
                        sh0   <= r_seg;
                        state <= EXP1;
                    end else begin
                        state <= HUNT;
                    end
                end else begin
                    state <= exp_state(slot_idx + 2'd1);
                    unique case (slot_idx)
                        2'd0: sh0 <= r_seg;
                        2'd1: sh1 <= r_seg;
                        2'd2: sh2 <= r_seg;
                        2'd3: begin
                            Dig       <= {r_seg, sh2, sh1, sh0};
                            Frame_vld <= 1'b1;
                            Frame_cnt <= Frame_cnt + 8'd1;
                            Sync      <= 1'b1;
                        end
                    endcase
                end
            end else if (timeout) begin
                state <= HUNT;
                Sync  <= 1'b0;
            end
        end
    end

endmodule
